// File: rtl/uart_cmd_sender.sv
// uart_cmd_sender: host-side initiator of the glitcher configuration byte
// protocol. A start strobe snapshots the pulse parameters. The block then
// streams the selected command/argument bytes to a byte-level UART transmitter
// using a data / one-cycle-enable / busy handshake.
//
// Burst layout as ten fixed slots. Unselected fields are skipped by the slot
// search, so the byte index is always a slot number.
//   slot 0..2 : 0x00, delay[15:8], delay[7:0]
//   slot 3..4 : 0x01, width
//   slot 5..6 : 0x02, num_pulses
//   slot 7..9 : 0x03, spacing[15:8], spacing[7:0]
module uart_cmd_sender (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [3:0]  send_mask_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_en_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] SLOT_NONE = 4'd15;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_mask;
  logic [15:0] r_delay;
  logic [7:0]  r_width;
  logic [7:0]  r_num;
  logic [15:0] r_spacing;
  logic [3:0]  r_slot;

  logic [7:0]  r_tx_data;
  logic        r_tx_en;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_tx_data_nxt;
  logic        w_tx_en_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  logic        w_start_go;
  logic        w_start_empty;
  logic [3:0]  w_first_slot;
  logic [3:0]  w_next_slot;
  logic [7:0]  w_cur_byte;

  // Which mask bit (field) owns a given slot.
  function automatic logic [1:0] slot_field(input logic [3:0] slot);
    logic [1:0] f;
    case (slot)
      4'd0, 4'd1, 4'd2: f = 2'd0;
      4'd3, 4'd4:       f = 2'd1;
      4'd5, 4'd6:       f = 2'd2;
      default:          f = 2'd3;
    endcase
    return f;
  endfunction

  // Lowest selected slot at or above 'from'; SLOT_NONE when the burst is over.
  function automatic logic [3:0] find_slot(input logic [3:0] mask,
                                           input logic [3:0] from);
    logic [3:0] res;
    res = SLOT_NONE;
    for (int s = 9; s >= 0; s--) begin
      if ((4'(s) >= from) && mask[slot_field(4'(s))]) res = 4'(s);
    end
    return res;
  endfunction

  // Byte carried by a slot, taken from the snapshot.
  function automatic logic [7:0] slot_byte(input logic [3:0]  slot,
                                           input logic [15:0] dly,
                                           input logic [7:0]  wid,
                                           input logic [7:0]  num,
                                           input logic [15:0] spc);
    logic [7:0] b;
    case (slot)
      4'd0:    b = 8'h00;
      4'd1:    b = dly[15:8];
      4'd2:    b = dly[7:0];
      4'd3:    b = 8'h01;
      4'd4:    b = wid;
      4'd5:    b = 8'h02;
      4'd6:    b = num;
      4'd7:    b = 8'h03;
      4'd8:    b = spc[15:8];
      default: b = spc[7:0];
    endcase
    return b;
  endfunction

  assign w_start_go    = start_i && (send_mask_i != 4'd0);
  assign w_start_empty = start_i && (send_mask_i == 4'd0);
  assign w_first_slot  = find_slot(send_mask_i, 4'd0);
  assign w_next_slot   = find_slot(r_mask, r_slot + 4'd1);
  assign w_cur_byte    = slot_byte(r_slot, r_delay, r_width, r_num, r_spacing);

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. GAP lasts exactly one cycle and ignores tx_busy_i to
  // cover the transmitter's busy-assert latency.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_go) w_state_nxt = S_ISSUE;
      S_ISSUE:  if (!tx_busy_i) w_state_nxt = S_GAP;
      S_GAP:    w_state_nxt = (w_next_slot != SLOT_NONE) ? S_ISSUE : S_FINISH;
      S_FINISH: if (!tx_busy_i) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_tx_data_nxt = r_tx_data;
    w_tx_en_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_go)    w_busy_nxt = 1'b1;
        if (w_start_empty) w_done_nxt = 1'b1;
      end
      S_ISSUE: begin
        if (!tx_busy_i) begin
          w_tx_data_nxt = w_cur_byte;
          w_tx_en_nxt   = 1'b1;
        end
      end
      S_FINISH: begin
        if (!tx_busy_i) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tx_data <= w_tx_data_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Parameter snapshot (only taken from IDLE) and current slot pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask    <= 4'd0;
      r_delay   <= 16'd0;
      r_width   <= 8'd0;
      r_num     <= 8'd0;
      r_spacing <= 16'd0;
      r_slot    <= 4'd0;
    end else if ((r_state == S_IDLE) && w_start_go) begin
      r_mask    <= send_mask_i;
      r_delay   <= delay_i;
      r_width   <= width_i;
      r_num     <= num_pulses_i;
      r_spacing <= pulse_spacing_i;
      r_slot    <= w_first_slot;
    end else if ((r_state == S_GAP) && (w_next_slot != SLOT_NONE)) begin
      r_slot    <= w_next_slot;
    end
  end

  assign tx_data_o = r_tx_data;
  assign tx_en_o   = r_tx_en;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule
